pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Consumes cache handshakes
//  (ihit/dhit), load-use and branch-resolve conditions, and halt, and drives per-latch

---
 rtl/pipeline_ctrl.sv | 84 ++++++++
 tb/tb_pipeline_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer driving latch enables, bubbles and PC enable
// for the 5-stage pipeline, with saturating stall and branch-flush counters.
module pipeline_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req_3,
  input  logic             dREN_out_2,
  input  logic [4:0]       rt_out_2,
  input  logic [4:0]       rs_in_2,
  input  logic [4:0]       rt_in_2,
  input  logic             uses_rt_in_2,
  input  logic             pc_src_3,
  input  logic             halt_out_4,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int LW = (LU_BUBBLES > 1) ? $clog2(LU_BUBBLES) : 1;
  localparam logic [1:0] RUN = 2'd0, DWAIT = 2'd1, LUSTALL = 2'd2, HALT = 2'd3;
  logic [1:0] state, nextState;
  logic [LW-1:0] luCnt, nextLu;
  logic [7:0] ctl;
  logic brTaken, loadUse, luPend;
  assign loadUse = dREN_out_2 && rt_out_2 != 5'd0 &&
                   (rt_out_2 == rs_in_2 || (uses_rt_in_2 && rt_out_2 == rt_in_2));
  // a miss during LUSTALL parks the remaining bubble count in luCnt across DWAIT
  assign luPend = state == LUSTALL || (state == DWAIT && luCnt != '0);
  always_comb begin
    ctl = '0;
    nextState = state;
    nextLu = luCnt;
    brTaken = 1'b0;
    if (state == HALT) nextState = HALT;
    else if (state != DWAIT && halt_out_4) nextState = HALT;
    else if (state == DWAIT ? !dhit : (mem_req_3 && !dhit)) nextState = DWAIT;
    else if (pc_src_3) begin
      ctl = 8'b11111_111;
      brTaken = 1'b1;
      nextState = RUN;
      nextLu = '0;
    end else if (luPend || loadUse) begin
      ctl = 8'b00111_010;
      if (luPend) begin
        nextLu = luCnt - LW'(1);
        nextState = (luCnt == LW'(1)) ? RUN : LUSTALL;
      end else if (LU_BUBBLES > 1) begin
        nextLu = LW'(LU_BUBBLES - 1);
        nextState = LUSTALL;
      end else nextState = RUN;
    end else begin
      ctl = ihit ? 8'b11111_000 : 8'b01111_100;
      nextState = RUN;
    end
  end
  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush} =
    nRST ? ctl : 8'b0;
  assign halt = state == HALT;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= RUN;
      luCnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= nextState;
      luCnt <= nextLu;
      if (state != HALT && !ctl[7] && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (brTaken && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of pipeline_ctrl with default, 3-bubble and
// 2-bit-counter instances sharing one stimulus stream.
module tb_pipeline_ctrl;
  logic CLK = 1'b0, nRST, ihit, dhit, mem_req_3, dREN_out_2, uses_rt_in_2, pc_src_3, halt_out_4;
  logic [4:0] rt_out_2, rs_in_2, rt_in_2;
  logic pe1, ie1, de1, xe1, we1, if1, df1, xf1, h1;
  logic pe3, ie3, de3, xe3, we3, if3, df3, xf3, h3;
  logic peS, ieS, deS, xeS, weS, ifS, dfS, xfS, hS;
  logic [15:0] s1, f1, s3, f3;
  logic [1:0] sS, fS;
  logic [8:0] o1, o3;
  int nTests = 0, nFail = 0;
  localparam logic [8:0] ZERO = 9'b000000000, ALL = 9'b111110000, LUO = 9'b001110100,
                         MISSO = 9'b011111000, BR = 9'b111111110, HALTO = 9'b000000001;
  assign o1 = {pe1, ie1, de1, xe1, we1, if1, df1, xf1, h1};
  assign o3 = {pe3, ie3, de3, xe3, we3, if3, df3, xf3, h3};
  always #5 CLK = ~CLK;
  pipeline_ctrl u1 (.CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req_3(mem_req_3),
    .dREN_out_2(dREN_out_2), .rt_out_2(rt_out_2), .rs_in_2(rs_in_2), .rt_in_2(rt_in_2),
    .uses_rt_in_2(uses_rt_in_2), .pc_src_3(pc_src_3), .halt_out_4(halt_out_4),
    .pc_en(pe1), .ifid_en(ie1), .idex_en(de1), .exmem_en(xe1), .memwb_en(we1),
    .ifid_flush(if1), .idex_flush(df1), .exmem_flush(xf1), .halt(h1),
    .stall_cnt(s1), .flush_cnt(f1));
  pipeline_ctrl #(.LU_BUBBLES(3)) u3 (.CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_req_3(mem_req_3), .dREN_out_2(dREN_out_2), .rt_out_2(rt_out_2), .rs_in_2(rs_in_2),
    .rt_in_2(rt_in_2), .uses_rt_in_2(uses_rt_in_2), .pc_src_3(pc_src_3), .halt_out_4(halt_out_4),
    .pc_en(pe3), .ifid_en(ie3), .idex_en(de3), .exmem_en(xe3), .memwb_en(we3),
    .ifid_flush(if3), .idex_flush(df3), .exmem_flush(xf3), .halt(h3),
    .stall_cnt(s3), .flush_cnt(f3));
  pipeline_ctrl #(.CNT_W(2)) uS (.CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_req_3(mem_req_3), .dREN_out_2(dREN_out_2), .rt_out_2(rt_out_2), .rs_in_2(rs_in_2),
    .rt_in_2(rt_in_2), .uses_rt_in_2(uses_rt_in_2), .pc_src_3(pc_src_3), .halt_out_4(halt_out_4),
    .pc_en(peS), .ifid_en(ieS), .idex_en(deS), .exmem_en(xeS), .memwb_en(weS),
    .ifid_flush(ifS), .idex_flush(dfS), .exmem_flush(xfS), .halt(hS),
    .stall_cnt(sS), .flush_cnt(fS));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic idle;
    {dhit, mem_req_3, dREN_out_2, uses_rt_in_2, pc_src_3, halt_out_4} = '0;
    ihit = 1'b1;
    {rt_out_2, rs_in_2, rt_in_2} = '0;
  endtask
  task automatic setLu;
    dREN_out_2 = 1'b1;
    rt_out_2 = 5'd3;
    rs_in_2 = 5'd3;
  endtask
  initial begin
    nRST = 1'b0;
    idle();
    tick();
    {ihit, dhit, mem_req_3, dREN_out_2, uses_rt_in_2, pc_src_3, halt_out_4} = 7'($urandom);
    {rt_out_2, rs_in_2, rt_in_2} = 15'($urandom);
    #1;
    chk("rst_o1", o1, ZERO);
    chk("rst_o3", o3, ZERO);
    tick();
    chk("rst_stall", s1, 0);
    chk("rst_flush", f1, 0);
    nRST = 1'b1;
    idle();
    #1 chk("run_idle", o1, ALL);
    tick();
    setLu();
    #1 chk("lu_rs", o1, LUO);
    tick();
    chk("lu_stall1", s1, 1);
    idle();
    #1 chk("after_lu", o1, ALL);
    tick();
    dREN_out_2 = 1'b1;
    #1 chk("lu_r0", o1, ALL);
    tick();
    idle();
    dREN_out_2 = 1'b1;
    rt_out_2 = 5'd7;
    rt_in_2 = 5'd7;
    uses_rt_in_2 = 1'b1;
    #1 chk("lu_rt", o1, LUO);
    tick();
    uses_rt_in_2 = 1'b0;
    #1 chk("lu_rt_unused", o1, ALL);
    tick();
    chk("lu_stall2", s1, 2);
    idle();
    ihit = 1'b0;
    #1 chk("imiss", o1, MISSO);
    tick();
    chk("imiss_stall", s1, 3);
    idle();
    mem_req_3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("dwait_frz", o1, ZERO);
      tick();
    end
    dhit = 1'b1;
    #1 chk("dhit_adv", o1, ALL);
    tick();
    chk("dwait_stall", s1, 7);
    chk("sat_stall", sS, 3);
    idle();
    setLu();
    ihit = 1'b0;
    pc_src_3 = 1'b1;
    #1 chk("br_lu", o1, BR);
    tick();
    chk("br_flush", f1, 1);
    chk("br_stall", s1, 7);
    idle();
    #1 chk("after_br", o1, ALL);
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    setLu();
    #1 chk("lu3_b1", o3, LUO);
    tick();
    idle();
    mem_req_3 = 1'b1;
    #1 chk("lu3_frz1", o3, ZERO);
    tick();
    #1 chk("lu3_frz2", o3, ZERO);
    tick();
    dhit = 1'b1;
    #1 chk("lu3_b2", o3, LUO);
    tick();
    idle();
    #1 chk("lu3_b3", o3, LUO);
    tick();
    #1 chk("lu3_done", o3, ALL);
    chk("lu3_stall", s3, 5);
    tick();
    setLu();
    #1 chk("lu3_again", o3, LUO);
    tick();
    idle();
    pc_src_3 = 1'b1;
    #1 chk("lu3_br", o3, BR);
    tick();
    idle();
    #1 chk("lu3_after_br", o3, ALL);
    chk("lu3_flush", f3, 1);
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    halt_out_4 = 1'b1;
    #1 chk("halt_req", o1, ZERO);
    tick();
    halt_out_4 = 1'b0;
    setLu();
    pc_src_3 = 1'b1;
    ihit = 1'b0;
    #1 chk("halted1", o1, HALTO);
    tick();
    mem_req_3 = 1'b1;
    #1 chk("halted2", o1, HALTO);
    tick();
    chk("halt_stall", s1, 1);
    chk("halt_flush", f1, 0);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    idle();
    #1 chk("post_halt", o1, ALL);
    tick();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
